// File: rtl/datamem_arbiter.sv
// -----------------------------------------------------------------------------
// DatamemArbiter
//
// Purpose:
//   Shares the single-port data memory between NREQ requesters (CPU load/store
//   unit, DMA, debug port). One access is serviced at a time, and requesters
//   take turns in round-robin order. Each access goes through
//   IDLE -> ACCESS -> RESP. The served requester receives a one-cycle done
//   pulse in RESP.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        per-requester request level, held until done
//   we         per-requester write enable (1 = write, 0 = read)
//   addr       packed addresses, requester i at [i*AW +: AW]
//   wdata      packed write data, requester i at [i*DW +: DW]
//   done       one-hot completion pulse, high for the RESP cycle only
//   rdata      read data captured from memory, valid with done of a read
//   busy       high while in ACCESS or RESP
//   owner      index of the requester currently or last served
//   mem_addr   memory address pins (hold last value outside ACCESS)
//   mem_rd     memory read strobe, high only in ACCESS for a read
//   mem_wr     memory write strobe, high only in ACCESS for a write
//   mem_wdata  memory write data pins
//   mem_rdata  memory read data (not driven while mem_rd is low)
// -----------------------------------------------------------------------------
module datamem_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 8,
  parameter int DW   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*AW-1:0]       addr,
  input  logic [NREQ*DW-1:0]       wdata,
  output logic [NREQ-1:0]          done,
  output logic [DW-1:0]            rdata,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [AW-1:0]            mem_addr,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata
);

  localparam int OW = $clog2(NREQ);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state;
  logic [OW-1:0] last_winner;
  logic [OW-1:0] win_idx;
  logic          win_found;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  // Round-robin pick. The search starts just after the last winner and wraps
  // around. The loop runs from the farthest offset down to the nearest, so the
  // nearest requesting index is the one that remains selected.
  always_comb begin
    int idx;
    idx       = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_winner) + k) % NREQ;
      if (req[idx]) begin
        win_idx   = idx[OW-1:0];
        win_found = 1'b1;
      end
    end
  end

  // Main sequencer. The winner's request is latched in IDLE, so later changes
  // on the requester's pins do not affect the access in flight.
  // last_winner is updated only when the access completes in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      last_winner <= OW'(NREQ - 1);
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            owner     <= win_idx;
            lat_we    <= we[win_idx];
            lat_addr  <= addr[win_idx*AW +: AW];
            lat_wdata <= wdata[win_idx*DW +: DW];
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!lat_we) begin
            rdata <= mem_rdata;
          end
          state <= RESP;
        end
        RESP: begin
          last_winner <= owner;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory strobes are decoded from the state register. They are also gated by
  // rst, so a reset asserted during ACCESS prevents a write from committing at
  // the end of that cycle.
  assign mem_rd    = (state == ACCESS) && !lat_we && !rst;
  assign mem_wr    = (state == ACCESS) &&  lat_we && !rst;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state == ACCESS) || (state == RESP);

  // Completion pulse to the owner. It is suppressed under reset, so an aborted
  // access never produces a done.
  always_comb begin
    done = '0;
    if ((state == RESP) && !rst) begin
      done[owner] = 1'b1;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_datamem_arbiter
//
// Purpose:
//   Directed testbench for datamem_arbiter. It runs two instances:
//   - a 2-requester instance connected to a 256x16 memory model;
//   - a 4-requester instance whose memory returns {8'hA0, address}.
//   Every expected value is hand-computed from the arbiter's behaviour.
// -----------------------------------------------------------------------------
module tb_datamem_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Two-requester instance and its memory model
  logic [1:0]  req2, we2, done2;
  logic [15:0] addr2;
  logic [31:0] wdata2;
  logic [15:0] rdata2, mem_wdata2, mem_rdata2;
  logic        busy2, mem_rd2, mem_wr2;
  logic [0:0]  owner2;
  logic [7:0]  mem_addr2;

  logic [15:0] mem2 [256];
  logic        p_en;
  logic [7:0]  p_addr;
  logic [15:0] p_data;

  // The bench preloads memory through the same write process the DUT uses,
  // which keeps the array written from a single process.
  always @(posedge clk) begin
    if (mem_wr2) begin
      mem2[mem_addr2] <= mem_wdata2;
    end else if (p_en) begin
      mem2[p_addr] <= p_data;
    end
  end

  assign mem_rdata2 = mem_rd2 ? mem2[mem_addr2] : 16'h0000;

  datamem_arbiter #(.NREQ(2), .AW(8), .DW(16)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .done(done2), .rdata(rdata2), .busy(busy2), .owner(owner2),
    .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  // Four-requester instance
  logic [3:0]  req4, we4, done4;
  logic [31:0] addr4;
  logic [63:0] wdata4;
  logic [15:0] rdata4, mem_wdata4, mem_rdata4;
  logic        busy4, mem_rd4, mem_wr4;
  logic [1:0]  owner4;
  logic [7:0]  mem_addr4;

  assign mem_rdata4 = mem_rd4 ? {8'hA0, mem_addr4} : 16'h0000;

  datamem_arbiter #(.NREQ(4), .AW(8), .DW(16)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
    .done(done4), .rdata(rdata4), .busy(busy4), .owner(owner4),
    .mem_addr(mem_addr4), .mem_rd(mem_rd4), .mem_wr(mem_wr4),
    .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
  );

  int nChecks = 0;
  int nPass   = 0;

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives one requester of the two-requester instance.
  task automatic applyStimulus(input int i, input logic r, input logic w,
                               input logic [7:0] a, input logic [15:0] d);
    req2[i]          = r;
    we2[i]           = w;
    addr2[i*8 +: 8]  = a;
    wdata2[i*16 +: 16] = d;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    p_en   = 1'b1;
    p_addr = a;
    p_data = d;
    @(negedge clk);
    p_en   = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [1:0]  expDone2 [4];
  logic [15:0] expData2 [4];
  int          expIdx4  [5];

  initial begin
    rst    = 1'b1;
    req2   = '0; we2 = '0; addr2 = '0; wdata2 = '0;
    req4   = '0; we4 = '0; wdata4 = '0;
    addr4  = {8'h43, 8'h42, 8'h41, 8'h40};
    p_en   = 1'b0; p_addr = '0; p_data = '0;

    tick();
    preload(8'h10, 16'hBEEF);
    preload(8'h30, 16'hAAAA);
    preload(8'h31, 16'h5555);
    preload(8'h20, 16'h0001);

    // Reset values
    checkOutput("rst_done",  32'(done2), 32'h0);
    checkOutput("rst_busy",  32'(busy2), 32'h0);
    checkOutput("rst_owner", 32'(owner2), 32'h0);
    checkOutput("rst_rdata", 32'(rdata2), 32'h0);
    checkOutput("rst_strb",  32'({mem_rd2, mem_wr2}), 32'h0);
    checkOutput("rst_maddr", 32'(mem_addr2), 32'h0);
    checkOutput("rst_busy4", 32'(busy4), 32'h0);
    rst = 1'b0;
    tick();

    // Single read by requester 0
    applyStimulus(0, 1'b1, 1'b0, 8'h10, 16'h0);
    tick();
    checkOutput("rd_acc_rd",    32'(mem_rd2), 32'h1);
    checkOutput("rd_acc_wr",    32'(mem_wr2), 32'h0);
    checkOutput("rd_acc_addr",  32'(mem_addr2), 32'h10);
    checkOutput("rd_acc_busy",  32'(busy2), 32'h1);
    checkOutput("rd_acc_done",  32'(done2), 32'h0);
    tick();
    checkOutput("rd_resp_done", 32'(done2), 32'h1);
    checkOutput("rd_resp_data", 32'(rdata2), 32'hBEEF);
    checkOutput("rd_resp_rd",   32'(mem_rd2), 32'h0);
    checkOutput("rd_resp_own",  32'(owner2), 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0);
    tick();
    checkOutput("rd_idle_done", 32'(done2), 32'h0);
    checkOutput("rd_idle_busy", 32'(busy2), 32'h0);
    checkOutput("rd_idle_data", 32'(rdata2), 32'hBEEF);
    checkOutput("rd_idle_addr", 32'(mem_addr2), 32'h10);

    // Write then read by requester 1
    applyStimulus(1, 1'b1, 1'b1, 8'hFF, 16'h1234);
    tick();
    checkOutput("wr_acc_wr",    32'(mem_wr2), 32'h1);
    checkOutput("wr_acc_rd",    32'(mem_rd2), 32'h0);
    checkOutput("wr_acc_addr",  32'(mem_addr2), 32'hFF);
    checkOutput("wr_acc_wdata", 32'(mem_wdata2), 32'h1234);
    checkOutput("wr_acc_own",   32'(owner2), 32'h1);
    tick();
    checkOutput("wr_resp_done", 32'(done2), 32'h2);
    checkOutput("wr_resp_data", 32'(rdata2), 32'hBEEF);
    checkOutput("wr_mem",       32'(mem2[8'hFF]), 32'h1234);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 16'h0);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 8'hFF, 16'h0);
    tick();
    checkOutput("rb_acc_rd",    32'(mem_rd2), 32'h1);
    tick();
    checkOutput("rb_resp_done", 32'(done2), 32'h2);
    checkOutput("rb_resp_data", 32'(rdata2), 32'h1234);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 16'h0);
    tick();

    // Contention: both requesters hold reads and are served alternately
    expDone2 = '{2'b01, 2'b10, 2'b01, 2'b10};
    expData2 = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
    applyStimulus(0, 1'b1, 1'b0, 8'h30, 16'h0);
    applyStimulus(1, 1'b1, 1'b0, 8'h31, 16'h0);
    for (int g = 0; g < 4; g++) begin
      tick();
      checkOutput("ct_acc_done",  32'(done2), 32'h0);
      checkOutput("ct_acc_busy",  32'(busy2), 32'h1);
      tick();
      checkOutput("ct_resp_done", 32'(done2), 32'(expDone2[g]));
      checkOutput("ct_resp_data", 32'(rdata2), 32'(expData2[g]));
      if (g == 3) begin
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 8'h00, 16'h0);
      end
      tick();
      checkOutput("ct_idle_done", 32'(done2), 32'h0);
    end

    // Fairness with four requesters, all requesting
    expIdx4 = '{0, 1, 2, 3, 0};
    req4 = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      checkOutput("fr_acc_own",   32'(owner4), 32'(expIdx4[g]));
      checkOutput("fr_acc_busy",  32'(busy4), 32'h1);
      tick();
      checkOutput("fr_resp_done", 32'(done4), 32'(4'b0001 << expIdx4[g]));
      checkOutput("fr_resp_data", 32'(rdata4), 32'(16'hA040 + expIdx4[g]));
      if (g == 4) begin
        req4 = 4'b0000;
      end
      tick();
      checkOutput("fr_idle_done", 32'(done4), 32'h0);
    end
    repeat (3) tick();
    req4 = 4'b0100;
    tick();
    checkOutput("fr2_acc_own",   32'(owner4), 32'h2);
    tick();
    checkOutput("fr2_resp_done", 32'(done4), 32'h4);
    checkOutput("fr2_resp_data", 32'(rdata4), 32'hA042);
    req4 = 4'b0000;
    tick();

    // Reset asserted during the ACCESS cycle of a write
    applyStimulus(1, 1'b1, 1'b1, 8'h20, 16'h5555);
    tick();
    checkOutput("ra_acc_wr",  32'(mem_wr2), 32'h1);
    checkOutput("ra_acc_own", 32'(owner2), 32'h1);
    rst = 1'b1;
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 16'h0);
    #1;
    checkOutput("ra_rst_strb", 32'({mem_rd2, mem_wr2}), 32'h0);
    checkOutput("ra_rst_done", 32'(done2), 32'h0);
    tick();
    checkOutput("ra_mem",     32'(mem2[8'h20]), 32'h0001);
    checkOutput("ra_done",    32'(done2), 32'h0);
    checkOutput("ra_busy",    32'(busy2), 32'h0);
    checkOutput("ra_owner",   32'(owner2), 32'h0);
    checkOutput("ra_rdata",   32'(rdata2), 32'h0);
    checkOutput("ra_maddr",   32'(mem_addr2), 32'h0);
    checkOutput("ra_mwdata",  32'(mem_wdata2), 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("ra_post_done", 32'(done2), 32'h0);
    checkOutput("ra_post_mem",  32'(mem2[8'h20]), 32'h0001);

    // Idle: nothing moves without requests
    repeat (20) begin
      tick();
      checkOutput("idle2", 32'({mem_rd2, mem_wr2, busy2, done2}), 32'h0);
      checkOutput("idle4", 32'({mem_rd4, mem_wr4, busy4, done4}), 32'h0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
